store_checker: RTL and testbench
================================

# store_checker

Synthesizable self-check monitor for the pipelined CPU's data-memory write port. It sits beside `top` and watches `memwrite`/`dataadr`/`writedata`. It matches stores in order against a programmable table of expected (address, data) pairs and silently ignores stores that fall in a configurable scratch-address window. It reports pass/fail with a failure code, the offending store, and the run length, so benches and FPGA builds share one checker instead of hard-coded negedge comparisons.

## Interface
Parameters:
- `WIDTH`, 32, address/data width
- `DEPTH`, 4, expected-store table entries
- `IGN_ADDR`, 32'd80, scratch-window address; stores here are ignored
- `IGN_MASK`, 32'hFFFF_FFFF, address bits compared for the ignore window
- `TIMEOUT`, 1000, RUN cycles before timeout failure; 0 disables timeout
- `IW`, $clog2(DEPTH), table index width; `CW`, $clog2(DEPTH+1), count width

Ports:
- `clk` in 1: the only clock; all logic on posedge
- `reset` in 1: synchronous, active-high
- `cfg_we` in 1: write table entry `cfg_idx`
- `cfg_idx` in IW: table index
- `cfg_addr`, `cfg_data` in WIDTH: expected store address and data
- `cfg_len` in CW: number of expected stores, latched on `start`
- `start` in 1: arm the checker
- `memwrite` in 1, `dataadr` in WIDTH, `writedata` in WIDTH: monitored store port
- `busy` out 1: in RUN
- `done` out 1: in PASS or FAIL
- `pass` out 1: in PASS
- `fail_code` out 2: 0 none, 1 unexpected store, 2 timeout, 3 bad length
- `match_cnt` out CW: expected stores matched so far
- `fail_addr`, `fail_data` out WIDTH: store that caused code 1
- `cycles` out 32: RUN cycles elapsed; saturates at 2^32-1

## Operation
- States: IDLE, RUN, PASS, FAIL.
- Reset: state goes to IDLE. All outputs are 0, the table is cleared to 0, and the latched length is 0.
- `cfg_we` is accepted in IDLE, PASS and FAIL, and ignored in RUN. `cfg_idx >= DEPTH` is ignored.
- `start` in IDLE/PASS/FAIL:
  - If `cfg_len == 0` or `cfg_len > DEPTH`: go to FAIL with code 3.
  - Otherwise go to RUN. Clear `match_cnt`, `cycles`, `fail_*` and `fail_code`, and latch `cfg_len`.
  - `start` during RUN is ignored.
- RUN, each cycle: `cycles` increments. If `memwrite`=1, checks apply in this priority:
  1. Both `dataadr` and `writedata` equal table[`match_cnt`]: `match_cnt` increments. If the new count equals the latched length, go to PASS.
  2. `(dataadr & IGN_MASK) == (IGN_ADDR & IGN_MASK)`: the store is ignored.
  3. Otherwise: go to FAIL with code 1, capturing `fail_addr`=`dataadr` and `fail_data`=`writedata`.
- Timeout: when `TIMEOUT != 0`, on the RUN cycle where `cycles == TIMEOUT-1` (the pre-increment value) with no transition from the rule above, go to FAIL with code 2.
- Simultaneous events on the timeout cycle:
  - A completing match wins, giving PASS.
  - An unexpected store wins, giving code 1.
- PASS/FAIL are sticky: `cycles` and `match_cnt` freeze and `memwrite` is ignored until `start` or `reset`.
- Equality uses `==` on all WIDTH bits. The table is read combinationally at index `match_cnt`.

## Timing
- All outputs are registered.
- `start` sampled at edge N: `busy`=1 (or `done`=1 with code 3) after edge N.
- Store sampled at edge M: `match_cnt`, `done`, `pass`, `fail_*` update after edge M, a 1-cycle latency.
- `cfg_we` at edge K: the entry is usable by a `start` at edge K+1 or later. `cfg_we` and `start` in the same cycle write first, and the run sees the new entry.
- Timeout: `done`=1 and `cycles`=TIMEOUT exactly TIMEOUT cycles after `busy` rises.
- `reset` overrides all other inputs, including mid-RUN. Outputs are 0 after that edge.

## Test plan
- Entry0=(84,7), len=1, start. Store (80,3), then (84,7) → first store ignored, `match_cnt` stays 0. One cycle after the second store: `pass`=1, `done`=1, `match_cnt`=1, `fail_code`=0.
- Same table, store (88,7) → next cycle `done`=1, `pass`=0, `fail_code`=1, `fail_addr`=88, `fail_data`=7. A later (84,7) leaves the outputs unchanged.
- TIMEOUT=20, len=1, no stores → `done`=1, `fail_code`=2, `cycles`=20, exactly 20 cycles after `busy` rises.
- `cfg_len`=0, then `cfg_len`=5 with DEPTH=4 → each start yields `fail_code`=3 and `busy`=0 one cycle later.
- Table (80,1),(84,2),(88,3), len=3:
  - Stores (80,1),(84,2),(88,3) → PASS. The store at 80 counts as a match, not as ignored.
  - Re-armed with first store (84,2) → FAIL code 1, `fail_addr`=84.
- Reset mid-RUN after one match → all outputs 0 next cycle. Reprogram, start, complete → PASS.
- A final match on the timeout cycle (TIMEOUT=20) → PASS with `cycles`=20.

Source files
------------

// File: rtl/store_checker_if.sv
// Bundles the configuration, monitored store port and status signals of store_checker.
//   master : drives the table and length config, start, and the store port; reads status.
//   slave  : the checker side.
//   cfg_we/cfg_idx/cfg_addr/cfg_data : table write port
//   cfg_len/start                    : expected store count and arm strobe
//   memwrite/dataadr/writedata       : CPU data-memory write port being watched
//   busy/done/pass/fail_code/match_cnt/fail_addr/fail_data/cycles : registered status
interface store_checker_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IW    = 2,
  parameter int unsigned CW    = 3
);
  logic             cfg_we;
  logic [IW-1:0]    cfg_idx;
  logic [WIDTH-1:0] cfg_addr;
  logic [WIDTH-1:0] cfg_data;
  logic [CW-1:0]    cfg_len;
  logic             start;
  logic             memwrite;
  logic [WIDTH-1:0] dataadr;
  logic [WIDTH-1:0] writedata;
  logic             busy;
  logic             done;
  logic             pass;
  logic [1:0]       fail_code;
  logic [CW-1:0]    match_cnt;
  logic [WIDTH-1:0] fail_addr;
  logic [WIDTH-1:0] fail_data;
  logic [31:0]      cycles;

  modport master (
    output cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_len, start,
    output memwrite, dataadr, writedata,
    input  busy, done, pass, fail_code, match_cnt, fail_addr, fail_data, cycles
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_len, start,
    input  memwrite, dataadr, writedata,
    output busy, done, pass, fail_code, match_cnt, fail_addr, fail_data, cycles
  );
endinterface

// File: rtl/store_checker.sv
// In-order checker for the CPU data-memory write port. Stores are matched against a
// programmable table of (address, data) pairs; stores into the scratch window are skipped.
// Reports pass/fail, a failure code, the offending store and the run length in cycles.
//   clk   : sole clock, posedge
//   reset : synchronous, active-high
//   bus   : store_checker_if slave (config, start, monitored store port, status)
// The interface must be instantiated with matching WIDTH/IW/CW. DEPTH must be >= 2.
module store_checker #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] IGN_ADDR = WIDTH'(80),
  parameter logic [WIDTH-1:0] IGN_MASK = {WIDTH{1'b1}},
  parameter int unsigned      TIMEOUT  = 1000,
  parameter int unsigned      IW       = $clog2(DEPTH),
  parameter int unsigned      CW       = $clog2(DEPTH + 1)
) (
  input logic           clk,
  input logic           reset,
  store_checker_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

  localparam logic [1:0] CodeNone    = 2'd0;
  localparam logic [1:0] CodeUnexp   = 2'd1;
  localparam logic [1:0] CodeTimeout = 2'd2;
  localparam logic [1:0] CodeBadLen  = 2'd3;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tbl_addr_q [DEPTH];
  logic [WIDTH-1:0] tbl_data_q [DEPTH];
  logic [CW-1:0]    len_q, len_d;
  logic [CW-1:0]    match_cnt_q, match_cnt_d;
  logic [31:0]      cycles_q, cycles_d;
  logic [1:0]       fail_code_q, fail_code_d;
  logic [WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [WIDTH-1:0] fail_data_q, fail_data_d;

  logic             tbl_we;
  logic [IW-1:0]    rd_idx;
  logic [WIDTH-1:0] exp_addr, exp_data;
  logic             hit, ignored;
  logic [CW-1:0]    match_inc;

  assign tbl_we    = bus.cfg_we && (state_q != StRun) && (32'(bus.cfg_idx) < DEPTH);
  // In RUN match_cnt < len <= DEPTH, so the low IW bits always address a valid entry.
  assign rd_idx    = match_cnt_q[IW-1:0];
  assign exp_addr  = tbl_addr_q[rd_idx];
  assign exp_data  = tbl_data_q[rd_idx];
  assign hit       = (bus.dataadr == exp_addr) && (bus.writedata == exp_data);
  assign ignored   = (bus.dataadr & IGN_MASK) == (IGN_ADDR & IGN_MASK);
  assign match_inc = match_cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    match_cnt_d = match_cnt_q;
    cycles_d    = cycles_q;
    fail_code_d = fail_code_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;

    unique case (state_q)
      StRun: begin
        if (cycles_q != 32'hFFFF_FFFF) begin
          cycles_d = cycles_q + 32'd1;
        end
        if (bus.memwrite) begin
          if (hit) begin
            match_cnt_d = match_inc;
            if (match_inc == len_q) begin
              state_d = StPass;
            end
          end else if (!ignored) begin
            state_d     = StFail;
            fail_code_d = CodeUnexp;
            fail_addr_d = bus.dataadr;
            fail_data_d = bus.writedata;
          end
        end
        // Timeout only fires if the store rules did not already end the run.
        if ((TIMEOUT != 0) && (cycles_q == 32'(TIMEOUT - 1)) && (state_d == StRun)) begin
          state_d     = StFail;
          fail_code_d = CodeTimeout;
        end
      end
      default: begin
        if (bus.start) begin
          if ((bus.cfg_len == '0) || (32'(bus.cfg_len) > DEPTH)) begin
            state_d     = StFail;
            fail_code_d = CodeBadLen;
          end else begin
            state_d     = StRun;
            len_d       = bus.cfg_len;
            match_cnt_d = '0;
            cycles_d    = '0;
            fail_code_d = CodeNone;
            fail_addr_d = '0;
            fail_data_d = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      match_cnt_q <= '0;
      cycles_q    <= '0;
      fail_code_q <= CodeNone;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tbl_addr_q[i] <= '0;
        tbl_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      match_cnt_q <= match_cnt_d;
      cycles_q    <= cycles_d;
      fail_code_q <= fail_code_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      if (tbl_we) begin
        tbl_addr_q[bus.cfg_idx] <= bus.cfg_addr;
        tbl_data_q[bus.cfg_idx] <= bus.cfg_data;
      end
    end
  end

  assign bus.busy      = (state_q == StRun);
  assign bus.done      = (state_q == StPass) || (state_q == StFail);
  assign bus.pass      = (state_q == StPass);
  assign bus.fail_code = fail_code_q;
  assign bus.match_cnt = match_cnt_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_data = fail_data_q;
  assign bus.cycles    = cycles_q;

endmodule

// File: tb/tb_store_checker.sv
// Directed bench for store_checker (DEPTH=4, TIMEOUT=20, scratch window at address 80).
module tb_store_checker;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IW    = 2;
  localparam int unsigned CW    = 3;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  store_checker_if #(.WIDTH(WIDTH), .IW(IW), .CW(CW)) bus ();

  store_checker #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .IGN_ADDR(32'd80),
    .IGN_MASK(32'hFFFF_FFFF),
    .TIMEOUT (20),
    .IW      (IW),
    .CW      (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int idx, input logic [31:0] a, input logic [31:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = IW'(idx);
    bus.cfg_addr = a;
    bus.cfg_data = d;
    step();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic arm(input int len);
    bus.cfg_len = CW'(len);
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite  = 1'b1;
    bus.dataadr   = a;
    bus.writedata = d;
    step();
    bus.memwrite  = 1'b0;
  endtask

  initial begin
    int n;
    reset         = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_idx   = '0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.cfg_len   = '0;
    bus.start     = 1'b0;
    bus.memwrite  = 1'b0;
    bus.dataadr   = '0;
    bus.writedata = '0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_pass", 32'(bus.pass), 0);
    chk("rst_code", 32'(bus.fail_code), 0);
    chk("rst_match", 32'(bus.match_cnt), 0);
    chk("rst_faddr", bus.fail_addr, 0);
    chk("rst_cycles", bus.cycles, 0);

    // Ignored scratch store, then the expected store
    cfg(0, 84, 7);
    arm(1);
    chk("t1_busy", 32'(bus.busy), 1);
    store(80, 3);
    chk("t1_ign_match", 32'(bus.match_cnt), 0);
    chk("t1_ign_busy", 32'(bus.busy), 1);
    store(84, 7);
    chk("t1_pass", 32'(bus.pass), 1);
    chk("t1_done", 32'(bus.done), 1);
    chk("t1_match", 32'(bus.match_cnt), 1);
    chk("t1_code", 32'(bus.fail_code), 0);
    chk("t1_cycles", bus.cycles, 2);
    step();
    chk("t1_cycles_frozen", bus.cycles, 2);

    // Unexpected store, then sticky FAIL
    arm(1);
    store(88, 7);
    chk("t2_done", 32'(bus.done), 1);
    chk("t2_pass", 32'(bus.pass), 0);
    chk("t2_code", 32'(bus.fail_code), 1);
    chk("t2_faddr", bus.fail_addr, 88);
    chk("t2_fdata", bus.fail_data, 7);
    store(84, 7);
    chk("t2_sticky_code", 32'(bus.fail_code), 1);
    chk("t2_sticky_match", 32'(bus.match_cnt), 0);
    chk("t2_sticky_faddr", bus.fail_addr, 88);

    // Timeout with no stores
    arm(1);
    chk("t3_busy", 32'(bus.busy), 1);
    n = 0;
    while (!bus.done && n < 100) begin
      step();
      n++;
    end
    chk("t3_latency", 32'(n), 20);
    chk("t3_code", 32'(bus.fail_code), 2);
    chk("t3_cycles", bus.cycles, 20);

    // Length above DEPTH
    arm(5);
    chk("t4_len5_code", 32'(bus.fail_code), 3);
    chk("t4_len5_busy", 32'(bus.busy), 0);
    chk("t4_len5_done", 32'(bus.done), 1);

    // Three-entry table; store at 80 is a match, not ignored; cfg in RUN is dropped
    cfg(0, 80, 1);
    cfg(1, 84, 2);
    cfg(2, 88, 3);
    arm(3);
    chk("t5_busy", 32'(bus.busy), 1);
    chk("t5_code_clr", 32'(bus.fail_code), 0);
    store(80, 1);
    chk("t5_match1", 32'(bus.match_cnt), 1);
    cfg(1, 0, 0);
    store(84, 2);
    chk("t5_match2", 32'(bus.match_cnt), 2);
    store(88, 3);
    chk("t5_pass", 32'(bus.pass), 1);
    chk("t5_match3", 32'(bus.match_cnt), 3);
    chk("t5_code", 32'(bus.fail_code), 0);

    // Zero length
    arm(0);
    chk("t4_len0_code", 32'(bus.fail_code), 3);
    chk("t4_len0_busy", 32'(bus.busy), 0);
    chk("t4_len0_pass", 32'(bus.pass), 0);

    // Out-of-order first store
    arm(3);
    store(84, 2);
    chk("t5b_code", 32'(bus.fail_code), 1);
    chk("t5b_faddr", bus.fail_addr, 84);
    chk("t5b_fdata", bus.fail_data, 2);

    // Table write and start in the same cycle: the run sees the new entry
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = 2'd0;
    bus.cfg_addr = 32'd84;
    bus.cfg_data = 32'd2;
    bus.cfg_len  = 3'd1;
    bus.start    = 1'b1;
    step();
    bus.cfg_we   = 1'b0;
    bus.start    = 1'b0;
    chk("t5c_busy", 32'(bus.busy), 1);
    store(84, 2);
    chk("t5c_pass", 32'(bus.pass), 1);

    // Reset mid-RUN after one match
    cfg(0, 100, 5);
    arm(2);
    store(100, 5);
    chk("t6_match1", 32'(bus.match_cnt), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_done", 32'(bus.done), 0);
    chk("t6_match", 32'(bus.match_cnt), 0);
    chk("t6_cycles", bus.cycles, 0);
    chk("t6_code", 32'(bus.fail_code), 0);
    // Cleared table expects (0,0) in entry 0
    arm(1);
    store(0, 0);
    chk("t6_tbl_clear_pass", 32'(bus.pass), 1);
    cfg(0, 100, 5);
    cfg(1, 104, 6);
    arm(2);
    store(100, 5);
    store(104, 6);
    chk("t6_repass", 32'(bus.pass), 1);
    chk("t6_rematch", 32'(bus.match_cnt), 2);

    // Completing match on the timeout cycle
    arm(1);
    for (int i = 0; i < 19; i++) step();
    chk("t7_busy19", 32'(bus.busy), 1);
    chk("t7_cycles19", bus.cycles, 19);
    store(100, 5);
    chk("t7_pass", 32'(bus.pass), 1);
    chk("t7_code", 32'(bus.fail_code), 0);
    chk("t7_cycles", bus.cycles, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
